// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and the data
//   (load/store) stage. Data has priority; a saturating starvation counter
//   forces a fetch grant after STARVE_MAX consecutive data grants made while
//   fetch was waiting. Each access is sequenced IDLE -> WRITE -> IDLE for
//   stores, and IDLE -> READ_WAIT (RD_LAT cycles) -> RESP -> IDLE for reads.
//
//   Parameters: RD_LAT (1..4) read latency, STARVE_MAX fetch starvation bound.
//   Optional:   define MEM_ALIGN_CHECK_EN to add dm_err and suppress
//               misaligned data accesses (granted, never issued).
//
//   Ports:
//     clk, rst               clock (rising edge), async active-low reset
//     if_req/if_adr          fetch request (word reads only)
//     if_gnt/if_rvalid/if_rdata  fetch grant pulse, response pulse, data
//     dm_req/dm_we/dm_size/dm_adr/dm_wdata  data request fields
//     dm_gnt/dm_rvalid/dm_rdata  data grant pulse, load response, data
//     dm_err                 misaligned-access pulse (MEM_ALIGN_CHECK_EN only)
//     mem_read/mem_write/mem_size/mem_adr/mem_wdata/mem_rdata  memory port
module mem_port_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_adr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        dm_err,
`endif
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned   SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [1:0]    LAT_LAST   = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          run;        // low until the first clock edge after reset release
  logic          owner_dm;   // 1 = data port owns the access in flight
  logic [1:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          fetch_win, data_win, dm_misaligned, lat_last;
`ifdef MEM_ALIGN_CHECK_EN
  logic          err_pend, err_store;
`endif

`ifdef MEM_ALIGN_CHECK_EN
  assign dm_misaligned = ((dm_size == 2'd0) && (dm_adr[1:0] != 2'b00)) ||
                         ((dm_size == 2'd2) && dm_adr[0]);
`else
  assign dm_misaligned = 1'b0;
`endif

  assign lat_last = (lat_cnt == LAT_LAST);

  // Winner selection: data first, unless fetch has waited STARVE_MAX grants.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (state == IDLE && run) begin
      if (if_req && (!dm_req || starve_cnt == STARVE_LIM)) fetch_win = 1'b1;
      else if (dm_req)                                     data_win  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_win)          state_nxt = READ_WAIT;
        else if (data_win) begin
          if (dm_misaligned)    state_nxt = RESP;
          else if (dm_we)       state_nxt = WRITE;
          else                  state_nxt = READ_WAIT;
        end
      end
      WRITE:     state_nxt = IDLE;
      READ_WAIT: if (lat_last) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and owner
  always_comb begin
    if_gnt    = fetch_win;
    dm_gnt    = data_win;
    if_rvalid = (state == RESP) && !owner_dm;
`ifdef MEM_ALIGN_CHECK_EN
    dm_rvalid = (state == RESP) && owner_dm && !err_store;
    dm_err    = (state == RESP) && err_pend;
`else
    dm_rvalid = (state == RESP) && owner_dm;
`endif
  end

  // Memory port registers, latency/starvation counters, response data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run        <= 1'b0;
      owner_dm   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_size   <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_pend   <= 1'b0;
      err_store  <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (fetch_win) begin
            owner_dm   <= 1'b0;
            mem_read   <= 1'b1;
            mem_adr    <= if_adr;
            mem_size   <= 2'd0;
            starve_cnt <= '0;
          end else if (data_win) begin
            owner_dm  <= 1'b1;
            mem_adr   <= dm_adr;
            mem_size  <= dm_size;
            mem_wdata <= dm_wdata;
            mem_read  <= !dm_we && !dm_misaligned;
            mem_write <= dm_we && !dm_misaligned;
            if (!if_req)                        starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)  starve_cnt <= starve_cnt + 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            err_pend  <= dm_misaligned;
            err_store <= dm_misaligned && dm_we;
            if (dm_misaligned && !dm_we) dm_rdata <= '0;
`endif
          end else if (!if_req) begin
            starve_cnt <= '0;
          end
        end
        WRITE: mem_write <= 1'b0;
        READ_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_last) begin
            mem_read <= 1'b0;
            // Loading the owner's data register here makes it change exactly
            // as rvalid rises, and hold between pulses.
            if (owner_dm) dm_rdata <= mem_rdata;
            else          if_rdata <= mem_rdata;
          end
        end
        RESP: begin
`ifdef MEM_ALIGN_CHECK_EN
          err_pend  <= 1'b0;
          err_store <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. Instance u_dut (RD_LAT=1, STARVE_MAX=3) is
//   checked every cycle against a transaction-timeline model; instance
//   u_dut4 (RD_LAT=4) gets directed latency checks.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int RD_LAT     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_adr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [1:0]  dm_size = '0;
  logic [31:0] dm_adr = '0, dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [31:0] mem_word = '0;

  logic        b_if_req = 1'b0;
  logic [31:0] b_if_adr = '0;
  logic        b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_rdata;
  logic        b_dm_req = 1'b0, b_dm_we = 1'b0;
  logic [1:0]  b_dm_size = '0;
  logic [31:0] b_dm_adr = '0, b_dm_wdata = '0;
  logic        b_dm_gnt, b_dm_rvalid;
  logic [31:0] b_dm_rdata;
  logic        b_dm_err;
  logic        b_mem_read, b_mem_write;
  logic [1:0]  b_mem_size;
  logic [31:0] b_mem_adr, b_mem_wdata, b_mem_rdata;
  int          b_rdcnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifndef MEM_ALIGN_CHECK_EN
  assign dm_err   = 1'b0;
  assign b_dm_err = 1'b0;
`endif

  // Memory returns the word only while it is being read, garbage otherwise.
  assign mem_rdata   = mem_read ? mem_word : 32'hBAD0_BAD0;
  // Second memory returns the load word only on the 4th read cycle.
  assign b_mem_rdata = (b_mem_read && b_rdcnt == 3) ? 32'h0000_001F : 32'hBAD0_0BAD;
  always @(posedge clk) b_rdcnt <= b_mem_read ? b_rdcnt + 1 : 0;

  logic [31:0] out_or;
  assign out_or = if_rdata | dm_rdata | mem_adr | mem_wdata |
                  {25'b0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_read, mem_write} |
                  {30'b0, mem_size};

  mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .dm_err(dm_err),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.RD_LAT(4), .STARVE_MAX(STARVE_MAX)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_adr(b_if_adr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_size(b_dm_size), .dm_adr(b_dm_adr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .dm_err(b_dm_err),
`endif
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_size(b_mem_size), .mem_adr(b_mem_adr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == 2'd0 && a[1:0] != 2'b00) || (sz == 2'd2 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- model: each access is a timeline from its grant -------
  logic armed = 1'b0;   // first edge after reset release has happened
  always @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  bit          m_busy = 0, m_dm = 0, m_we = 0, m_mis = 0;
  int          m_t = 0, m_starve = 0;
  logic [31:0] m_adr = '0, m_wd = '0, m_word = '0, m_if_rd = '0, m_dm_rd = '0;
  logic [1:0]  m_sz = '0;
  logic        e_ifg, e_dmg, e_ifv, e_dmv, e_err, e_mr, e_mw;

  always @(negedge clk) begin
    if (!rst || !armed) begin
      if (!rst) begin
        m_busy = 0; m_starve = 0; m_if_rd = '0; m_dm_rd = '0;
      end
      chk("reset_outputs_zero", out_or, 32'h0);
    end else begin
      {e_ifg, e_dmg, e_ifv, e_dmv, e_err, e_mr, e_mw} = '0;
      if (m_busy) begin
        m_t++;
        if (m_mis) begin
          e_err = 1'b1;
          if (!m_we) begin e_dmv = 1'b1; m_dm_rd = '0; end
          m_busy = 0;
        end else if (m_we) begin
          e_mw = 1'b1;
          m_busy = 0;
        end else if (m_t <= RD_LAT) begin
          e_mr = 1'b1;
        end else begin
          if (m_dm) begin e_dmv = 1'b1; m_dm_rd = m_word; end
          else      begin e_ifv = 1'b1; m_if_rd = m_word; end
          m_busy = 0;
        end
      end else begin
        if (!if_req) m_starve = 0;
        if (if_req && (!dm_req || m_starve == STARVE_MAX)) begin
          e_ifg = 1'b1; m_busy = 1; m_t = 0; m_dm = 0; m_we = 0; m_mis = 0;
          m_adr = if_adr; m_sz = 2'd0; m_word = mem_word; m_starve = 0;
        end else if (dm_req) begin
          e_dmg = 1'b1; m_busy = 1; m_t = 0; m_dm = 1; m_we = dm_we;
          m_mis = misal(dm_size, dm_adr);
          m_adr = dm_adr; m_sz = dm_size; m_wd = dm_wdata; m_word = mem_word;
          if (if_req && m_starve < STARVE_MAX) m_starve++;
        end
      end
      chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_ifg});
      chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dmg});
      chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_ifv});
      chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, e_dmv});
      chk("dm_err", {31'b0, dm_err}, {31'b0, e_err});
      chk("mem_read", {31'b0, mem_read}, {31'b0, e_mr});
      chk("mem_write", {31'b0, mem_write}, {31'b0, e_mw});
      chk("if_rdata", if_rdata, m_if_rd);
      chk("dm_rdata", dm_rdata, m_dm_rd);
      if (e_mr || e_mw) begin
        chk("mem_adr", mem_adr, m_adr);
        chk("mem_size", {30'b0, mem_size}, {30'b0, m_sz});
      end
      if (e_mw) chk("mem_wdata", mem_wdata, m_wd);
    end
  end

  // ---------------- directed stimulus --------------------------------------
  int          r_g, r_v, r_rd, r_wr, r_ifv, r_dmv, r_err;
  logic [31:0] r_data, r_adr, r_wd;
  logic [1:0]  r_sz;

  // Run ncyc cycles, recording what the port did; drop the request on grant.
  task automatic observe(input bit fetch, input int ncyc);
    r_g = -1; r_v = -1; r_rd = 0; r_wr = 0; r_ifv = 0; r_dmv = 0; r_err = 0;
    r_data = '0; r_adr = '0; r_wd = '0; r_sz = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin r_adr = mem_adr; r_sz = mem_size; r_wd = mem_wdata; end
      r_rd  += int'(mem_read);
      r_wr  += int'(mem_write);
      r_err += int'(dm_err);
      if (if_rvalid) begin r_ifv++; if (fetch)  begin r_v = c; r_data = if_rdata; end end
      if (dm_rvalid) begin r_dmv++; if (!fetch) begin r_v = c; r_data = dm_rdata; end end
      if ((fetch && if_gnt) || (!fetch && dm_gnt)) begin
        if (r_g < 0) r_g = c;
        @(posedge clk); #1;
        if (fetch) if_req = 1'b0; else dm_req = 1'b0;
      end
    end
  endtask

  task automatic start_dm(input bit we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word);
    @(posedge clk); #1;
    dm_we = we; dm_size = sz; dm_adr = a; dm_wdata = wd; mem_word = word; dm_req = 1'b1;
  endtask

  int          ng, bg, bv, brd, bifv, fcnt;
  logic [31:0] bdata;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("lit_reset_zero", out_or, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch only: gnt at cycle 0, one read cycle at 0x8, rvalid at cycle 2
    @(posedge clk); #1;
    if_adr = 32'h0000_0008; mem_word = 32'h2008_0005; if_req = 1'b1;
    observe(1'b1, 6);
    chk("fetch_gnt_cycle", r_g, 0);
    chk("fetch_read_cycles", r_rd, 1);
    chk("fetch_mem_adr", r_adr, 32'h8);
    chk("fetch_mem_size", {30'b0, r_sz}, 32'h0);
    chk("fetch_rvalid_cycle", r_v, 2);
    chk("fetch_rdata", r_data, 32'h2008_0005);
    chk("fetch_dm_rvalid", r_dmv, 0);

    // Store byte
    start_dm(1'b1, 2'd1, 32'h13, 32'hAB, 32'h0);
    observe(1'b0, 6);
    chk("store_gnt_cycle", r_g, 0);
    chk("store_write_cycles", r_wr, 1);
    chk("store_read_cycles", r_rd, 0);
    chk("store_mem_adr", r_adr, 32'h13);
    chk("store_mem_size", {30'b0, r_sz}, 32'h1);
    chk("store_mem_wdata", r_wd, 32'hAB);
    chk("store_no_rvalid", r_ifv + r_dmv, 0);

    // Halfword load: data passes through unmodified
    start_dm(1'b0, 2'd2, 32'h22, 32'h0, 32'hCAFE_8001);
    observe(1'b0, 6);
    chk("ldh_rvalid_cycle", r_v, 2);
    chk("ldh_rdata", r_data, 32'hCAFE_8001);
    chk("ldh_mem_size", {30'b0, r_sz}, 32'h2);
    chk("ldh_if_rvalid", r_ifv, 0);

    // Contention: both held high -> D D D F D D D F ...
    @(posedge clk); #1;
    if_adr = 32'h40; mem_word = 32'h0; dm_we = 1'b1; dm_size = 2'd0;
    dm_adr = 32'h100; dm_wdata = 32'h55; if_req = 1'b1; dm_req = 1'b1;
    ng = 0; fcnt = 0;
    for (int c = 0; c < 300 && ng < 16; c++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        chk($sformatf("contention_grant%0d_is_fetch", ng), {31'b0, if_gnt},
            (ng % 4 == 3) ? 32'h1 : 32'h0);
        fcnt += int'(if_gnt);
        ng++;
      end
    end
    chk("contention_grant_count", ng, 16);
    chk("contention_fetch_count", fcnt, 4);
    @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0;
    repeat (8) @(negedge clk);

    // RD_LAT=4 load on the second instance
    @(posedge clk); #1;
    b_dm_adr = 32'h40; b_dm_size = 2'd0; b_dm_we = 1'b0; b_dm_req = 1'b1;
    bg = -1; bv = -1; brd = 0; bifv = 0; bdata = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      brd  += int'(b_mem_read);
      bifv += int'(b_if_rvalid);
      if (b_dm_rvalid) begin bv = c; bdata = b_dm_rdata; end
      if (b_dm_gnt) begin
        if (bg < 0) bg = c;
        @(posedge clk); #1; b_dm_req = 1'b0;
      end
    end
    chk("lat4_gnt_cycle", bg, 0);
    chk("lat4_rvalid_after_gnt", bv - bg, 5);
    chk("lat4_mem_read_cycles", brd, 4);
    chk("lat4_rdata", bdata, 32'h0000_001F);
    chk("lat4_if_rvalid", bifv, 0);

    // Asynchronous reset in READ_WAIT, then a fresh fetch
    @(posedge clk); #1;
    if_adr = 32'h30; mem_word = 32'h1111_2222; if_req = 1'b1;
    ng = 0;
    for (int c = 0; c < 10 && ng == 0; c++) begin
      @(negedge clk);
      if (if_gnt) ng = 1;
    end
    chk("rst_fetch_granted", ng, 1);
    @(posedge clk); #1; if_req = 1'b0;
    #1;
    chk("rst_pre_mem_read", {31'b0, mem_read}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_async_zero", out_or, 32'h0);
    fcnt = 0;
    repeat (3) begin @(negedge clk); fcnt += int'(if_rvalid); end
    @(posedge clk); #1;
    rst = 1'b1;
    if_adr = 32'h34; mem_word = 32'h0BAD_F00D; if_req = 1'b1;
    observe(1'b1, 8);
    fcnt += r_ifv;
    chk("post_rst_gnt_cycle", r_g, 1);
    chk("post_rst_rvalid_cycle", r_v, 3);
    chk("post_rst_rdata", r_data, 32'h0BAD_F00D);
    chk("post_rst_rvalid_count", fcnt, 1);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load: granted, never issued, error + zero data
    start_dm(1'b0, 2'd0, 32'h6, 32'h0, 32'h7777_7777);
    observe(1'b0, 6);
    chk("mis_ld_gnt_cycle", r_g, 0);
    chk("mis_ld_read_cycles", r_rd, 0);
    chk("mis_ld_err", r_err, 1);
    chk("mis_ld_rvalid_cycle", r_v, 1);
    chk("mis_ld_rdata", r_data, 32'h0);
    // Misaligned halfword store: error only
    start_dm(1'b1, 2'd2, 32'h3, 32'h99, 32'h0);
    observe(1'b0, 6);
    chk("mis_st_write_cycles", r_wr, 0);
    chk("mis_st_err", r_err, 1);
    chk("mis_st_rvalid", r_dmv, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
